ar_tx_arb: RTL and testbench
============================

AR_TX_ARB -- requirements
Module: ar_tx_arb

Interface
REQ-001 Parameter GAP_BITS, default 4: minimum inter-word gap, counted in ce_tact pulses after the transmitter goes idle.
REQ-002 Parameter START_TO, default 255: clk cycles allowed between tx_st and tx_busy rising.
REQ-003 The block SHALL use one clock and a synchronous active-low reset: clk (input, 1 bit, system clock) and rst_n (input, 1 bit, synchronous active-low reset).
REQ-004 req  input  4  per-requester word request; requester i holds it high until ack[i].
REQ-005 adr_in  input  32  packed addresses; requester i uses bits [8i+7:8i].
REQ-006 dat_in  input  92  packed data; requester i uses bits [23i+22:23i].
REQ-007 nvel_in  input  8  packed speed codes; requester i uses bits [2i+1:2i].
REQ-008 ack  output  4  one-cycle pulse; the word of requester i has been latched.
REQ-009 tx_adr  output  8  address to the transmitter; held stable from latch to the next latch.
REQ-010 tx_dat  output  23  data to the transmitter; held like tx_adr.
REQ-011 tx_nvel  output  2  speed code to the transmitter; held like tx_adr.
REQ-012 tx_st  output  1  one-cycle start strobe to the transmitter.
REQ-013 tx_busy  input  1  word-in-progress flag from the transmitter (its en_tx_word).
REQ-014 ce_tact  input  1  bit-period strobe from the transmitter.
REQ-015 grant_id  output  2  index of the requester currently served.
REQ-016 busy  output  1  high whenever the state is not IDLE.
REQ-017 done  output  1  one-cycle pulse on tx_busy falling in BUSY.
REQ-018 err  output  1  one-cycle pulse on start timeout.
REQ-019 err_cnt  output  8  timeout count; saturates at 255.

Function
REQ-020 The FSM SHALL have the states IDLE, START, WAIT_BUSY, BUSY and GAP.
REQ-021 IDLE arbitration:
- req is sampled only in IDLE.
- The winner is the first asserted bit searching upward from ptr+1, mod 4.
- In the same cycle: latch the winner's adr/dat/nvel into tx_*, set grant_id and ptr to the winner, pulse ack[winner], go to START.
REQ-022 START SHALL drive tx_st=1 for exactly one cycle, clear the timer and go to WAIT_BUSY.
REQ-023 WAIT_BUSY:
- tx_busy=1 → go to BUSY.
- Otherwise increment the timer; when the timer equals START_TO, pulse err, increment err_cnt (saturating) and go to GAP.
REQ-024 BUSY SHALL wait for tx_busy=0, then pulse done, clear the gap counter and go to GAP.
REQ-025 GAP:
- Count ce_tact pulses.
- When the count reaches GAP_BITS, go to IDLE.
- ce_tact is ignored in every other state.
REQ-026 Latency: with req[i]=1 and state IDLE at edge n, ack[i] and the new tx_* appear after edge n; tx_st appears after edge n+1.
REQ-027 A requester dropping req before being granted SHALL be ignored, with no ack.
REQ-028 req high on the same cycle as its own ack SHALL NOT be granted twice; ack ends the request, and re-assertion is seen at the next IDLE.
REQ-029 Simultaneous requests SHALL be served round-robin; no requester waits more than 3 words.
REQ-030 tx_busy rising outside WAIT_BUSY SHALL be ignored; tx_busy falling outside BUSY SHALL be ignored.
REQ-031 ptr SHALL wrap 3→0.
REQ-032 Only GAP_BITS=0 skips the ce_tact count: GAP returns to IDLE on the next cycle.
REQ-033 ack, tx_st, done and err SHALL never be high for more than one consecutive cycle.

Reset
REQ-034 rst_n=0 at a clk edge SHALL force, from any state:
- state IDLE, ptr=3 (requester 0 has first priority);
- ack, tx_st, done, err, busy, grant_id, tx_adr, tx_dat, tx_nvel, err_cnt and all timers/counters to 0.
REQ-035 Reset mid-word SHALL abandon the word with no ack, done or err pulse; the first grant after release follows REQ-021 with ptr=3.

Verification
REQ-036 Single word: req=0001, adr0=8'hA5, dat0=23'h12345, nvel0=2 → ack=0001 next cycle; tx_adr=A5, tx_dat=12345, tx_nvel=2; tx_st one cycle later; done after tx_busy falls; busy drops GAP_BITS ce_tact pulses later.
REQ-037 Round-robin: req=1111 held, each re-asserted after its ack → grant order 0,1,2,3,0; no grant issued during BUSY or GAP.
REQ-038 Start timeout: tx_busy held 0 → err pulse exactly START_TO+1 cycles after tx_st; err_cnt=1; after the gap, the next requester is served.
REQ-039 err_cnt saturation: 256 forced timeouts → err_cnt=255; err still pulses each time.
REQ-040 Reset in BUSY: rst_n=0 one cycle while tx_busy=1 → all outputs 0 next cycle; with req=1000 after release → grant_id=3 and ptr=3, then req=1001 → requester 0 served next.
REQ-041 Withdrawn request: req[2] pulsed for 1 cycle during BUSY → no ack[2] ever.

Source files
------------

// File: rtl/ar_tx_arb_if.sv
// ar_tx_arb_if: requester and transmitter signal bundle for the round-robin word arbiter
// slave (arbiter side): in  req[4], adr_in[32], dat_in[92], nvel_in[8], tx_busy, ce_tact
//                       out ack[4], tx_adr[8], tx_dat[23], tx_nvel[2], tx_st,
//                           grant_id[2], busy, done, err, err_cnt[8]
// master is the mirror image for whoever drives the arbiter.
interface ar_tx_arb_if;
    logic [3:0]  req;
    logic [31:0] adr_in;
    logic [91:0] dat_in;
    logic [7:0]  nvel_in;
    logic [3:0]  ack;
    logic [7:0]  tx_adr;
    logic [22:0] tx_dat;
    logic [1:0]  tx_nvel;
    logic        tx_st;
    logic        tx_busy;
    logic        ce_tact;
    logic [1:0]  grant_id;
    logic        busy;
    logic        done;
    logic        err;
    logic [7:0]  err_cnt;
    modport slave (
        input  req, adr_in, dat_in, nvel_in, tx_busy, ce_tact,
        output ack, tx_adr, tx_dat, tx_nvel, tx_st, grant_id, busy, done, err, err_cnt
    );
    modport master (
        output req, adr_in, dat_in, nvel_in, tx_busy, ce_tact,
        input  ack, tx_adr, tx_dat, tx_nvel, tx_st, grant_id, busy, done, err, err_cnt
    );
endinterface

// File: rtl/ar_tx_arb.sv
// ar_tx_arb: round-robin arbiter feeding one word at a time from 4 requesters to a serial transmitter
// clk, rst_n (synchronous, active low); bus (ar_tx_arb_if.slave) carries requests, the
// latched word and start strobe to the transmitter, its busy/bit strobes, and status.
module ar_tx_arb #(
    parameter int GAP_BITS = 4,
    parameter int START_TO = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    ar_tx_arb_if.slave bus
);
    localparam int TW = $clog2(START_TO + 2);
    localparam int GW = $clog2(GAP_BITS + 2);

    typedef enum logic [2:0] {IDLE, START, WAIT_BUSY, BUSY, GAP} state_t;

    state_t        state_q, state_d;
    logic [1:0]    ptr_q, ptr_d, grant_q, grant_d;
    logic [3:0]    ack_q, ack_d;
    logic [7:0]    adr_q, adr_d;
    logic [22:0]   dat_q, dat_d;
    logic [1:0]    nvel_q, nvel_d;
    logic          tx_st_q, tx_st_d, done_q, done_d, err_q, err_d;
    logic [7:0]    err_cnt_q, err_cnt_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [3:0]    rot;
    logic [1:0]    off, win;
    logic          gap_end;

    // Rotate req so bit 0 is requester ptr+1; the lowest set bit then wins.
    always_comb begin
        rot     = 4'({bus.req, bus.req} >> (ptr_q + 2'd1));
        off     = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3;
        win     = ptr_q + 2'd1 + off;
        gap_end = (GAP_BITS == 0) || (bus.ce_tact && gap_q == GW'(GAP_BITS - 1));
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        grant_d   = grant_q;
        ack_d     = '0;
        adr_d     = adr_q;
        dat_d     = dat_q;
        nvel_d    = nvel_q;
        tx_st_d   = 1'b0;
        done_d    = 1'b0;
        err_d     = 1'b0;
        err_cnt_d = err_cnt_q;
        tmr_d     = '0;
        gap_d     = '0;
        case (state_q)
            IDLE: if (|bus.req) begin
                ptr_d   = win;
                grant_d = win;
                ack_d   = 4'b0001 << win;
                adr_d   = bus.adr_in[8*win +: 8];
                dat_d   = bus.dat_in[23*win +: 23];
                nvel_d  = bus.nvel_in[2*win +: 2];
                state_d = START;
            end
            START: begin
                tx_st_d = 1'b1;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: if (bus.tx_busy) begin
                state_d = BUSY;
            end else if (tmr_q == TW'(START_TO)) begin
                err_d     = 1'b1;
                err_cnt_d = err_cnt_q + 8'(~&err_cnt_q);
                state_d   = GAP;
            end else begin
                tmr_d = tmr_q + TW'(1);
            end
            BUSY: if (!bus.tx_busy) begin
                done_d  = 1'b1;
                state_d = GAP;
            end
            GAP: begin
                gap_d   = gap_q + GW'(bus.ce_tact);
                state_d = gap_end ? IDLE : GAP;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= 2'd3;
            grant_q   <= '0;
            ack_q     <= '0;
            adr_q     <= '0;
            dat_q     <= '0;
            nvel_q    <= '0;
            tx_st_q   <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
            tmr_q     <= '0;
            gap_q     <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            grant_q   <= grant_d;
            ack_q     <= ack_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            nvel_q    <= nvel_d;
            tx_st_q   <= tx_st_d;
            done_q    <= done_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
            tmr_q     <= tmr_d;
            gap_q     <= gap_d;
        end
    end

    assign bus.ack      = ack_q;
    assign bus.tx_adr   = adr_q;
    assign bus.tx_dat   = dat_q;
    assign bus.tx_nvel  = nvel_q;
    assign bus.tx_st    = tx_st_q;
    assign bus.grant_id = grant_q;
    assign bus.busy     = state_q != IDLE;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign bus.err_cnt  = err_cnt_q;
endmodule

// File: tb/tb_ar_tx_arb.sv
// tb_ar_tx_arb: directed bench for ar_tx_arb with a word-level reference model checked every cycle
module tb_ar_tx_arb;
    localparam int G = 2;
    localparam int T = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ar_tx_arb_if bus();
    ar_tx_arb_if bus0();

    ar_tx_arb #(.GAP_BITS(G), .START_TO(T)) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    ar_tx_arb #(.GAP_BITS(0), .START_TO(3)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));

    int checks = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] want);
        checks++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, want);
        end
    endtask

    // ---------------- reference model: one word per call, stepped edge by edge
    logic [3:0]  exp_ack = '0;
    logic [7:0]  exp_adr = '0;
    logic [22:0] exp_dat = '0;
    logic [1:0]  exp_nvel = '0;
    logic        exp_st = 1'b0, exp_done = 1'b0, exp_err = 1'b0, exp_busy = 1'b0;
    logic [1:0]  exp_gid = '0;
    logic [7:0]  exp_err_cnt = '0;
    int          m_ptr = 3;
    bit          rst_hit = 1'b0;

    task automatic tick();
        @(posedge clk);
        exp_ack = '0; exp_st = 1'b0; exp_done = 1'b0; exp_err = 1'b0;
        rst_hit = !rst_n;
        if (rst_hit) begin
            m_ptr = 3; exp_adr = '0; exp_dat = '0; exp_nvel = '0;
            exp_gid = '0; exp_busy = 1'b0; exp_err_cnt = '0;
        end
    endtask

    task automatic serve();
        int w = 0;
        int n = 0;
        bit to = 1'b0;
        for (int k = 1; k <= 4; k++)
            if (bus.req[(m_ptr + k) % 4] && n == 0) begin w = (m_ptr + k) % 4; n = 1; end
        m_ptr = w; exp_ack = 4'(1 << w); exp_gid = 2'(w); exp_busy = 1'b1;
        exp_adr = bus.adr_in[8*w +: 8]; exp_dat = bus.dat_in[23*w +: 23]; exp_nvel = bus.nvel_in[2*w +: 2];
        tick(); if (rst_hit) return;
        exp_st = 1'b1;
        n = 0;
        forever begin
            tick(); if (rst_hit) return;
            if (bus.tx_busy) break;
            if (n == T) begin
                to = 1'b1; exp_err = 1'b1;
                if (exp_err_cnt != 8'd255) exp_err_cnt++;
                break;
            end
            n++;
        end
        if (!to) begin
            forever begin
                tick(); if (rst_hit) return;
                if (!bus.tx_busy) break;
            end
            exp_done = 1'b1;
        end
        n = 0;
        forever begin
            tick(); if (rst_hit) return;
            if (bus.ce_tact) n++;
            if (n == G) break;
        end
        exp_busy = 1'b0;
    endtask

    initial forever begin
        tick();
        if (!rst_hit && bus.req != 0) serve();
    end

    always @(negedge clk) if (chk_en) begin
        chk("ack", 32'(bus.ack), 32'(exp_ack));
        chk("tx_adr", 32'(bus.tx_adr), 32'(exp_adr));
        chk("tx_dat", 32'(bus.tx_dat), 32'(exp_dat));
        chk("tx_nvel", 32'(bus.tx_nvel), 32'(exp_nvel));
        chk("tx_st", 32'(bus.tx_st), 32'(exp_st));
        chk("grant_id", 32'(bus.grant_id), 32'(exp_gid));
        chk("busy", 32'(bus.busy), 32'(exp_busy));
        chk("done", 32'(bus.done), 32'(exp_done));
        chk("err", 32'(bus.err), 32'(exp_err));
        chk("err_cnt", 32'(bus.err_cnt), 32'(exp_err_cnt));
    end

    // ---------------- stimulus: requesters, transmitter stand-in and bit strobe
    logic [3:0] rearm = '0;
    logic [3:0] acks[$];
    bit tx_en = 1'b1, spur = 1'b0;
    int blen = 3, tx_t = -1, ph = 0, ncyc = 0, done_n = 0, err_n = 0;

    task automatic cyc();
        @(posedge clk); #1;
        ncyc++;
        if (bus.ack != 0) acks.push_back(bus.ack);
        done_n += int'(bus.done);
        err_n += int'(bus.err);
        bus.req = (bus.req & ~bus.ack) | rearm;
        ph = (ph == 2) ? 0 : ph + 1;
        bus.ce_tact = (ph == 0);
        if (bus.tx_st && tx_en) tx_t = 0; else if (tx_t >= 0) tx_t++;
        if (tx_t >= 2 + blen) tx_t = -1;
        bus.tx_busy = spur || (tx_en && tx_t >= 2);
    endtask

    task automatic quiet(int lim, string nm);
        int k = 0;
        while (k < lim && (bus.req != 0 || bus.busy)) begin cyc(); k++; end
        chk({nm, "_quiet"}, 32'(bus.req == 0 && !bus.busy), 1);
    endtask

    task automatic rst_pulse();
        rst_n = 1'b0; cyc(); rst_n = 1'b1; cyc();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int t_st, t_err;
        bus.req = '0; bus.tx_busy = 1'b0; bus.ce_tact = 1'b0;
        bus.adr_in  = {8'h33, 8'h22, 8'h11, 8'hA5};
        bus.dat_in  = {23'h3AAAA, 23'h2BBBB, 23'h1CCCC, 23'h12345};
        bus.nvel_in = {2'd3, 2'd0, 2'd1, 2'd2};
        bus0.req = '0; bus0.adr_in = '0; bus0.dat_in = '0; bus0.nvel_in = '0;
        bus0.tx_busy = 1'b0; bus0.ce_tact = 1'b0;
        cyc(); cyc();
        chk_en = 1'b1;
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_err_cnt", 32'(bus.err_cnt), 0);
        chk("rst_tx_adr", 32'(bus.tx_adr), 0);
        rst_n = 1'b1;
        cyc();

        // single word
        bus.req = 4'b0001;
        cyc();
        chk("sw_ack", 32'(bus.ack), 1);
        chk("sw_adr", 32'(bus.tx_adr), 'hA5);
        chk("sw_dat", 32'(bus.tx_dat), 'h12345);
        chk("sw_nvel", 32'(bus.tx_nvel), 2);
        chk("sw_st_late", 32'(bus.tx_st), 0);
        cyc();
        chk("sw_st", 32'(bus.tx_st), 1);
        chk("sw_ack_once", 32'(bus.ack), 0);
        done_n = 0;
        quiet(100, "sw");
        chk("sw_done", 32'(done_n), 1);

        // round robin with all four held high
        rst_pulse();
        acks.delete();
        rearm = 4'hF; bus.req = 4'hF;
        for (int k = 0; k < 200 && acks.size() < 5; k++) cyc();
        rearm = '0;
        chk("rr_n", 32'(acks.size() >= 5), 1);
        for (int k = 0; k < 5 && k < acks.size(); k++)
            chk($sformatf("rr_order%0d", k), 32'(acks[k]), 32'(1 << (k % 4)));
        quiet(300, "rr");

        // withdrawn request during BUSY
        acks.delete();
        bus.req = 4'b0001;
        for (int k = 0; k < 50 && !bus.tx_busy; k++) cyc();
        cyc();
        bus.req = bus.req | 4'b0100;
        cyc();
        bus.req = bus.req & 4'b1011;
        quiet(100, "wd");
        chk("wd_acks", 32'(acks.size()), 1);
        foreach (acks[i]) chk("wd_no_ack2", 32'(acks[i][2]), 0);

        // start timeout
        tx_en = 1'b0; acks.delete(); err_n = 0; t_st = -1; t_err = -1;
        bus.req = 4'b0011;
        for (int k = 0; k < 100 && err_n == 0; k++) begin
            cyc();
            if (bus.tx_st && t_st < 0) t_st = ncyc;
            if (bus.err) t_err = ncyc;
        end
        chk("to_latency", 32'(t_err - t_st), T + 1);
        chk("to_err_cnt", 32'(bus.err_cnt), 1);
        quiet(100, "to");
        chk("to_first", acks.size() > 0 ? 32'(acks[0]) : 0, 'b0010);
        chk("to_next", acks.size() > 1 ? 32'(acks[1]) : 0, 'b0001);

        // saturation of err_cnt
        err_n = 0; rearm = 4'b0001; bus.req = 4'b0001;
        for (int k = 0; k < 8000 && err_n < 256; k++) cyc();
        chk("sat_pulses", 32'(err_n), 256);
        chk("sat_cnt", 32'(bus.err_cnt), 255);
        rearm = '0;
        quiet(100, "sat");
        chk("sat_hold", 32'(bus.err_cnt), 255);

        // reset while BUSY
        tx_en = 1'b1; blen = 20; bus.req = 4'b0001;
        for (int k = 0; k < 50 && !bus.tx_busy; k++) cyc();
        cyc(); cyc();
        chk("rb_in_busy", 32'(bus.busy), 1);
        rst_n = 1'b0; cyc();
        rst_n = 1'b1; tx_t = -1; bus.tx_busy = 1'b0; blen = 3;
        chk("rb_busy", 32'(bus.busy), 0);
        chk("rb_ack", 32'(bus.ack), 0);
        chk("rb_adr", 32'(bus.tx_adr), 0);
        chk("rb_dat", 32'(bus.tx_dat), 0);
        chk("rb_err_cnt", 32'(bus.err_cnt), 0);
        acks.delete(); done_n = 0;
        bus.req = 4'b1000;
        cyc();
        chk("rb_gid3", 32'(bus.grant_id), 3);
        chk("rb_ack3", 32'(bus.ack), 'b1000);
        bus.req = bus.req | 4'b1001;
        quiet(200, "rb");
        chk("rb_second", acks.size() > 1 ? 32'(acks[1]) : 0, 'b0001);
        chk("rb_third", acks.size() > 2 ? 32'(acks[2]) : 0, 'b1000);
        chk("rb_words", 32'(done_n), 3);

        // tx_busy toggling while idle is ignored
        spur = 1'b1; cyc(); cyc(); spur = 1'b0; cyc(); cyc();
        chk("sp_idle", 32'(bus.busy), 0);

        // GAP_BITS=0 instance: GAP lasts exactly one cycle
        bus0.req = 4'b0001;
        for (int k = 0; k < 20 && bus0.ack == 0; k++) cyc();
        bus0.req = '0;
        for (int k = 0; k < 30 && !bus0.err; k++) cyc();
        chk("g0_err", 32'(bus0.err), 1);
        chk("g0_busy_at_err", 32'(bus0.busy), 1);
        cyc();
        chk("g0_idle", 32'(bus0.busy), 0);

        cyc(); cyc();
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
